csr_issue: RTL and testbench

- Execute-stage initiator for the machine-mode CSR file.
- Accepts one CSR-class instruction (CSRRW/RS/RC, register or immediate form, MRET, or a pre-flagged exception) from decode via valid/ready.
- Performs the write-legality check, then drives a single-cycle access into the CSR file and captures its read data and trap outputs.
- Returns a result through a writeback valid/ready port or a one-cycle PC redirect.

---
 rtl/csr_pkg.sv | 48 ++++
 rtl/csr_access_check.sv | 40 ++++
 rtl/csr_issue.sv | 159 +++++++++++++++
 tb/tb_csr_issue.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared types, constants and helper functions for the CSR issue slice.
package csr_pkg;

    localparam int unsigned XlenDefault = 64;

    typedef enum logic [2:0] {
        OpNone  = 3'd0,
        OpCSRRW = 3'd1,
        OpCSRRS = 3'd2,
        OpCSRRC = 3'd3,
        OpMret  = 3'd4
    } csr_op_e;

    typedef enum logic [3:0] {
        CauseInstrMisaligned  = 4'd0,
        CauseInstrAccessFault = 4'd1,
        CauseIllegalInstr     = 4'd2,
        CauseBreakpoint       = 4'd3,
        CauseEcallU           = 4'd8,
        CauseEcallM           = 4'd11
    } csr_mcause_e;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWb,
        StRedirect
    } issue_state_e;

    localparam csr_mcause_e IllegalInstrCause = CauseIllegalInstr;

    // The top two address bits equal to 2'b11 mark a read-only CSR.
    function automatic logic csr_is_read_only(input logic [11:0] addr);
        return addr[11:10] == 2'b11;
    endfunction

    // CSRRW always writes. Set/clear only write when rs1 (or zimm) is non-zero.
    function automatic logic csr_op_writes(input csr_op_e op, input logic [4:0] rs1_idx);
        logic w;
        case (op)
            OpCSRRW:          w = 1'b1;
            OpCSRRS, OpCSRRC: w = (rs1_idx != 5'd0);
            default:          w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/csr_access_check.sv
// Write-legality check: merges an upstream exception with a read-only write violation.
module csr_access_check
    import csr_pkg::*;
#(
    parameter int unsigned Xlen          = 64,
    parameter bit          CheckReadOnly = 1'b1
) (
    input  csr_op_e           op,
    input  logic [4:0]        rs1_idx,
    input  logic [11:0]       addr,
    input  logic              expt_in_valid,
    input  csr_mcause_e       expt_in_cause,
    input  logic [Xlen-1:0]   expt_in_value,
    output logic              expt_valid,
    output csr_mcause_e       expt_cause,
    output logic [Xlen-1:0]   expt_value
);

    logic writes;
    logic illegal;

    // An upstream exception wins; otherwise a write to a read-only CSR becomes illegal-instruction.
    always_comb begin
        writes     = csr_op_writes(op, rs1_idx);
        illegal    = CheckReadOnly && writes && csr_is_read_only(addr);
        expt_valid = 1'b0;
        expt_cause = CauseInstrMisaligned;
        expt_value = '0;
        if (expt_in_valid) begin
            expt_valid = 1'b1;
            expt_cause = expt_in_cause;
            expt_value = expt_in_value;
        end else if (illegal) begin
            expt_valid = 1'b1;
            expt_cause = IllegalInstrCause;
            expt_value = '0;
        end
    end

endmodule

// File: rtl/csr_issue.sv
// Execute-stage initiator for the machine-mode CSR file: accept, issue one access, then writeback or redirect.
module csr_issue
    import csr_pkg::*;
#(
    parameter int unsigned Xlen          = XlenDefault,
    parameter bit          CheckReadOnly = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  csr_op_e           req_op_i,
    input  logic              req_imm_i,
    input  logic [4:0]        req_rs1_idx_i,
    input  logic [Xlen-1:0]   req_rs1_data_i,
    input  logic [4:0]        req_rd_idx_i,
    input  logic [11:0]       req_csr_addr_i,
    input  logic [Xlen-1:0]   req_pc_i,
    input  logic              req_expt_valid_i,
    input  csr_mcause_e       req_expt_cause_i,
    input  logic [Xlen-1:0]   req_expt_value_i,
    output logic              csr_valid_o,
    output csr_op_e           csr_op_o,
    output logic [11:0]       csr_addr_o,
    output logic [Xlen-1:0]   csr_wdata_o,
    output logic [Xlen-1:0]   csr_pc_o,
    output logic              csr_expt_valid_o,
    output csr_mcause_e       csr_expt_cause_o,
    output logic [Xlen-1:0]   csr_expt_value_o,
    output logic              csr_inst_ret_o,
    input  logic [Xlen-1:0]   csr_rdata_i,
    input  logic              csr_raise_trap_i,
    input  logic [Xlen-1:0]   csr_trap_vector_i,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [4:0]        wb_rd_idx_o,
    output logic [Xlen-1:0]   wb_data_o,
    output logic              redirect_valid_o,
    output logic [Xlen-1:0]   redirect_pc_o
);

    issue_state_e    state;
    csr_op_e         held_op;
    logic            chk_expt_valid;
    csr_mcause_e     chk_expt_cause;
    logic [Xlen-1:0] chk_expt_value;
    logic [Xlen-1:0] req_wdata;

    csr_access_check #(
        .Xlen          (Xlen),
        .CheckReadOnly (CheckReadOnly)
    ) u_check (
        .op            (req_op_i),
        .rs1_idx       (req_rs1_idx_i),
        .addr          (req_csr_addr_i),
        .expt_in_valid (req_expt_valid_i),
        .expt_in_cause (req_expt_cause_i),
        .expt_in_value (req_expt_value_i),
        .expt_valid    (chk_expt_valid),
        .expt_cause    (chk_expt_cause),
        .expt_value    (chk_expt_value)
    );

    // Immediate forms write the zero-extended zimm carried in the rs1 index field.
    always_comb begin
        req_wdata = req_imm_i ? {{(Xlen-5){1'b0}}, req_rs1_idx_i} : req_rs1_data_i;
    end

    // Issue FSM; every output is a register so decode never reaches the CSR file combinationally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state            <= StIdle;
            held_op          <= OpNone;
            req_ready_o      <= 1'b1;
            csr_valid_o      <= 1'b0;
            csr_op_o         <= OpNone;
            csr_addr_o       <= '0;
            csr_wdata_o      <= '0;
            csr_pc_o         <= '0;
            csr_expt_valid_o <= 1'b0;
            csr_expt_cause_o <= CauseInstrMisaligned;
            csr_expt_value_o <= '0;
            csr_inst_ret_o   <= 1'b0;
            wb_valid_o       <= 1'b0;
            wb_rd_idx_o      <= '0;
            wb_data_o        <= '0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (req_valid_i && req_ready_o) begin
                        state            <= StIssue;
                        req_ready_o      <= 1'b0;
                        held_op          <= req_op_i;
                        csr_valid_o      <= 1'b1;
                        csr_op_o         <= chk_expt_valid ? OpNone : req_op_i;
                        csr_addr_o       <= req_csr_addr_i;
                        csr_wdata_o      <= req_wdata;
                        csr_pc_o         <= req_pc_i;
                        csr_expt_valid_o <= chk_expt_valid;
                        csr_expt_cause_o <= chk_expt_cause;
                        csr_expt_value_o <= chk_expt_value;
                        csr_inst_ret_o   <= !chk_expt_valid;
                        wb_rd_idx_o      <= req_rd_idx_i;
                    end
                end
                StIssue: begin
                    csr_valid_o      <= 1'b0;
                    csr_op_o         <= OpNone;
                    csr_addr_o       <= '0;
                    csr_wdata_o      <= '0;
                    csr_pc_o         <= '0;
                    csr_expt_valid_o <= 1'b0;
                    csr_expt_cause_o <= CauseInstrMisaligned;
                    csr_expt_value_o <= '0;
                    csr_inst_ret_o   <= 1'b0;
                    wb_data_o        <= csr_rdata_i;
                    if (csr_raise_trap_i) begin
                        state            <= StRedirect;
                        redirect_valid_o <= 1'b1;
                        redirect_pc_o    <= csr_trap_vector_i;
                        wb_rd_idx_o      <= '0;
                        wb_data_o        <= '0;
                    end else if ((wb_rd_idx_o != 5'd0) &&
                                 ((held_op == OpCSRRW) || (held_op == OpCSRRS) || (held_op == OpCSRRC))) begin
                        state      <= StWb;
                        wb_valid_o <= 1'b1;
                    end else begin
                        state       <= StIdle;
                        req_ready_o <= 1'b1;
                        wb_rd_idx_o <= '0;
                        wb_data_o   <= '0;
                    end
                end
                StWb: begin
                    if (wb_ready_i) begin
                        state       <= StIdle;
                        req_ready_o <= 1'b1;
                        wb_valid_o  <= 1'b0;
                        wb_rd_idx_o <= '0;
                        wb_data_o   <= '0;
                    end
                end
                StRedirect: begin
                    state            <= StIdle;
                    req_ready_o      <= 1'b1;
                    redirect_valid_o <= 1'b0;
                    redirect_pc_o    <= '0;
                end
                default: begin
                    state       <= StIdle;
                    req_ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_issue.sv
// Directed self-checking bench for csr_issue with a tiny behavioural CSR file.
module tb_csr_issue;
    import csr_pkg::*;

    logic            clk;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    csr_op_e         req_op;
    logic            req_imm;
    logic [4:0]      req_rs1_idx;
    logic [63:0]     req_rs1_data;
    logic [4:0]      req_rd_idx;
    logic [11:0]     req_csr_addr;
    logic [63:0]     req_pc;
    logic            req_expt_valid;
    csr_mcause_e     req_expt_cause;
    logic [63:0]     req_expt_value;
    logic            csr_valid;
    csr_op_e         csr_op;
    logic [11:0]     csr_addr;
    logic [63:0]     csr_wdata;
    logic [63:0]     csr_pc;
    logic            csr_expt_valid;
    csr_mcause_e     csr_expt_cause;
    logic [63:0]     csr_expt_value;
    logic            csr_inst_ret;
    logic [63:0]     csr_rdata;
    logic            csr_raise_trap;
    logic [63:0]     csr_trap_vector;
    logic            wb_valid;
    logic            wb_ready;
    logic [4:0]      wb_rd_idx;
    logic [63:0]     wb_data;
    logic            redirect_valid;
    logic [63:0]     redirect_pc;

    int n_compared;
    int n_mismatched;

    localparam logic [63:0] MscratchVal = 64'hAA;
    localparam logic [63:0] HartId      = 64'h7;
    localparam logic [63:0] MtvecVal    = 64'h100;
    localparam logic [63:0] MepcVal     = 64'h8000_0040;

    csr_issue #(.Xlen(64), .CheckReadOnly(1'b1)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_op_i          (req_op),
        .req_imm_i         (req_imm),
        .req_rs1_idx_i     (req_rs1_idx),
        .req_rs1_data_i    (req_rs1_data),
        .req_rd_idx_i      (req_rd_idx),
        .req_csr_addr_i    (req_csr_addr),
        .req_pc_i          (req_pc),
        .req_expt_valid_i  (req_expt_valid),
        .req_expt_cause_i  (req_expt_cause),
        .req_expt_value_i  (req_expt_value),
        .csr_valid_o       (csr_valid),
        .csr_op_o          (csr_op),
        .csr_addr_o        (csr_addr),
        .csr_wdata_o       (csr_wdata),
        .csr_pc_o          (csr_pc),
        .csr_expt_valid_o  (csr_expt_valid),
        .csr_expt_cause_o  (csr_expt_cause),
        .csr_expt_value_o  (csr_expt_value),
        .csr_inst_ret_o    (csr_inst_ret),
        .csr_rdata_i       (csr_rdata),
        .csr_raise_trap_i  (csr_raise_trap),
        .csr_trap_vector_i (csr_trap_vector),
        .wb_valid_o        (wb_valid),
        .wb_ready_i        (wb_ready),
        .wb_rd_idx_o       (wb_rd_idx),
        .wb_data_o         (wb_data),
        .redirect_valid_o  (redirect_valid),
        .redirect_pc_o     (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in CSR file: fixed read values, traps on exceptions and MRET.
    always_comb begin
        csr_rdata = 64'h0;
        case (csr_addr)
            12'h340: csr_rdata = MscratchVal;
            12'hF14: csr_rdata = HartId;
            12'h305: csr_rdata = MtvecVal;
            default: csr_rdata = 64'h0;
        endcase
        csr_raise_trap  = csr_valid && (csr_expt_valid || (csr_op == OpMret));
        csr_trap_vector = (csr_op == OpMret) ? MepcVal : MtvecVal;
    end

    task automatic send(input csr_op_e op, input logic imm, input logic [4:0] rs1_idx,
                        input logic [63:0] rs1_data, input logic [4:0] rd, input logic [11:0] addr,
                        input logic [63:0] pc, input logic ev, input csr_mcause_e ec,
                        input logic [63:0] evalue);
        @(negedge clk);
        req_op = op; req_imm = imm; req_rs1_idx = rs1_idx; req_rs1_data = rs1_data;
        req_rd_idx = rd; req_csr_addr = addr; req_pc = pc;
        req_expt_valid = ev; req_expt_cause = ec; req_expt_value = evalue;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_compared++;
        if ({req_ready, csr_valid, wb_valid, redirect_valid, csr_inst_ret, csr_expt_valid} !== 6'b100000) begin
            n_mismatched++;
            $display("[TB] FAIL reset_flags: got %b expected 100000",
                     {req_ready, csr_valid, wb_valid, redirect_valid, csr_inst_ret, csr_expt_valid});
        end
        n_compared++;
        if ({csr_wdata, csr_pc, wb_data, redirect_pc, csr_addr, wb_rd_idx} !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_data: wdata %h pc %h wb %h redir %h expected all 0",
                     csr_wdata, csr_pc, wb_data, redirect_pc);
        end
    endtask

    task automatic test_csrrw();
        send(OpCSRRW, 1'b0, 5'd1, 64'h1234, 5'd5, 12'h340, 64'h8000_0000, 1'b0, CauseInstrMisaligned, 64'h0);
        @(negedge clk);
        n_compared++;
        if ({csr_valid, csr_inst_ret, csr_expt_valid, req_ready} !== 4'b1100 || csr_op !== OpCSRRW) begin
            n_mismatched++;
            $display("[TB] FAIL csrrw_issue: flags %b op %0d expected 1100 op 1",
                     {csr_valid, csr_inst_ret, csr_expt_valid, req_ready}, csr_op);
        end
        n_compared++;
        if (csr_wdata !== 64'h1234 || csr_addr !== 12'h340) begin
            n_mismatched++;
            $display("[TB] FAIL csrrw_wdata: got %h @%h expected 1234 @340", csr_wdata, csr_addr);
        end
        @(negedge clk);
        n_compared++;
        if ({csr_valid, wb_valid, redirect_valid} !== 3'b010 || wb_data !== MscratchVal || wb_rd_idx !== 5'd5) begin
            n_mismatched++;
            $display("[TB] FAIL csrrw_wb: flags %b data %h rd %0d expected 010 aa 5",
                     {csr_valid, wb_valid, redirect_valid}, wb_data, wb_rd_idx);
        end
        @(negedge clk);
        n_compared++;
        if ({wb_valid, req_ready} !== 2'b01) begin
            n_mismatched++;
            $display("[TB] FAIL csrrw_done: got %b expected 01", {wb_valid, req_ready});
        end
    endtask

    task automatic test_read_only();
        send(OpCSRRS, 1'b1, 5'd0, 64'hFFFF, 5'd6, 12'hF14, 64'h8000_0004, 1'b0, CauseInstrMisaligned, 64'h0);
        @(negedge clk);
        n_compared++;
        if ({csr_valid, csr_expt_valid, csr_inst_ret} !== 3'b101 || csr_op !== OpCSRRS || csr_wdata !== 64'h0) begin
            n_mismatched++;
            $display("[TB] FAIL csrrsi_legal: flags %b op %0d wdata %h expected 101 op 2 wdata 0",
                     {csr_valid, csr_expt_valid, csr_inst_ret}, csr_op, csr_wdata);
        end
        @(negedge clk);
        n_compared++;
        if ({wb_valid, redirect_valid} !== 2'b10 || wb_data !== HartId || wb_rd_idx !== 5'd6) begin
            n_mismatched++;
            $display("[TB] FAIL csrrsi_wb: flags %b data %h rd %0d expected 10 7 6",
                     {wb_valid, redirect_valid}, wb_data, wb_rd_idx);
        end
        @(negedge clk);
        send(OpCSRRW, 1'b1, 5'd3, 64'h0, 5'd6, 12'hF14, 64'h8000_0008, 1'b0, CauseInstrMisaligned, 64'h0);
        @(negedge clk);
        n_compared++;
        if ({csr_valid, csr_expt_valid, csr_inst_ret} !== 3'b110 || csr_op !== OpNone ||
            csr_expt_cause !== CauseIllegalInstr || csr_expt_value !== 64'h0 || csr_wdata !== 64'h3) begin
            n_mismatched++;
            $display("[TB] FAIL csrrwi_illegal: flags %b op %0d cause %0d value %h wdata %h expected 110 0 2 0 3",
                     {csr_valid, csr_expt_valid, csr_inst_ret}, csr_op, csr_expt_cause, csr_expt_value, csr_wdata);
        end
        @(negedge clk);
        n_compared++;
        if ({redirect_valid, wb_valid, csr_inst_ret} !== 3'b100 || redirect_pc !== MtvecVal) begin
            n_mismatched++;
            $display("[TB] FAIL csrrwi_redirect: flags %b pc %h expected 100 100",
                     {redirect_valid, wb_valid, csr_inst_ret}, redirect_pc);
        end
        @(negedge clk);
        n_compared++;
        if ({redirect_valid, wb_valid, req_ready} !== 3'b001) begin
            n_mismatched++;
            $display("[TB] FAIL csrrwi_after: got %b expected 001", {redirect_valid, wb_valid, req_ready});
        end
    endtask

    task automatic test_ecall();
        send(OpNone, 1'b0, 5'd0, 64'h0, 5'd0, 12'h000, 64'h8000_0010, 1'b1, CauseEcallM, 64'h0);
        @(negedge clk);
        n_compared++;
        if (csr_pc !== 64'h8000_0010 || {csr_valid, csr_expt_valid, csr_inst_ret} !== 3'b110 ||
            csr_expt_cause !== CauseEcallM) begin
            n_mismatched++;
            $display("[TB] FAIL ecall_issue: pc %h flags %b cause %0d expected 80000010 110 11",
                     csr_pc, {csr_valid, csr_expt_valid, csr_inst_ret}, csr_expt_cause);
        end
        @(negedge clk);
        n_compared++;
        if ({redirect_valid, wb_valid} !== 2'b10 || redirect_pc !== MtvecVal) begin
            n_mismatched++;
            $display("[TB] FAIL ecall_redirect: flags %b pc %h expected 10 100", {redirect_valid, wb_valid}, redirect_pc);
        end
        @(negedge clk);
        // Upstream breakpoint on an otherwise illegal write keeps the upstream cause and value.
        send(OpCSRRW, 1'b0, 5'd1, 64'h5, 5'd4, 12'hC00, 64'h8000_0020, 1'b1, CauseBreakpoint, 64'hDEAD);
        @(negedge clk);
        n_compared++;
        if (csr_expt_valid !== 1'b1 || csr_expt_cause !== CauseBreakpoint || csr_expt_value !== 64'hDEAD ||
            csr_op !== OpNone) begin
            n_mismatched++;
            $display("[TB] FAIL expt_priority: valid %b cause %0d value %h op %0d expected 1 3 dead 0",
                     csr_expt_valid, csr_expt_cause, csr_expt_value, csr_op);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mret();
        send(OpMret, 1'b0, 5'd0, 64'h0, 5'd0, 12'h302, 64'h8000_0030, 1'b0, CauseInstrMisaligned, 64'h0);
        @(negedge clk);
        n_compared++;
        if ({csr_valid, csr_inst_ret, csr_expt_valid} !== 3'b110 || csr_op !== OpMret) begin
            n_mismatched++;
            $display("[TB] FAIL mret_issue: flags %b op %0d expected 110 4",
                     {csr_valid, csr_inst_ret, csr_expt_valid}, csr_op);
        end
        @(negedge clk);
        n_compared++;
        if ({redirect_valid, wb_valid, csr_inst_ret} !== 3'b100 || redirect_pc !== MepcVal) begin
            n_mismatched++;
            $display("[TB] FAIL mret_redirect: flags %b pc %h expected 100 80000040",
                     {redirect_valid, wb_valid, csr_inst_ret}, redirect_pc);
        end
        @(negedge clk);
        n_compared++;
        if ({redirect_valid, req_ready} !== 2'b01) begin
            n_mismatched++;
            $display("[TB] FAIL mret_pulse: got %b expected 01", {redirect_valid, req_ready});
        end
    endtask

    task automatic test_wb_stall();
        wb_ready = 1'b0;
        send(OpCSRRC, 1'b0, 5'd2, 64'hF, 5'd9, 12'h340, 64'h8000_0050, 1'b0, CauseInstrMisaligned, 64'h0);
        @(negedge clk);
        n_compared++;
        if (csr_op !== OpCSRRC || csr_wdata !== 64'hF) begin
            n_mismatched++;
            $display("[TB] FAIL csrrc_issue: op %0d wdata %h expected 3 f", csr_op, csr_wdata);
        end
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_compared++;
            if ({wb_valid, req_ready, csr_valid} !== 3'b100 || wb_data !== MscratchVal || wb_rd_idx !== 5'd9) begin
                n_mismatched++;
                $display("[TB] FAIL wb_stall_%0d: flags %b data %h rd %0d expected 100 aa 9",
                         i, {wb_valid, req_ready, csr_valid}, wb_data, wb_rd_idx);
            end
        end
        req_valid = 1'b0;
        wb_ready  = 1'b1;
        @(negedge clk);
        n_compared++;
        if ({wb_valid, req_ready, csr_valid} !== 3'b010) begin
            n_mismatched++;
            $display("[TB] FAIL wb_release: got %b expected 010", {wb_valid, req_ready, csr_valid});
        end
    endtask

    task automatic test_back_to_back();
        send(OpCSRRS, 1'b0, 5'd0, 64'h0, 5'd0, 12'h340, 64'h8000_0060, 1'b0, CauseInstrMisaligned, 64'h0);
        @(negedge clk);
        @(negedge clk);
        n_compared++;
        if ({wb_valid, redirect_valid, req_ready} !== 3'b001) begin
            n_mismatched++;
            $display("[TB] FAIL rd0_no_wb: got %b expected 001", {wb_valid, redirect_valid, req_ready});
        end
        send(OpCSRRW, 1'b0, 5'd1, 64'h77, 5'd3, 12'h340, 64'h8000_0064, 1'b0, CauseInstrMisaligned, 64'h0);
        @(negedge clk);
        n_compared++;
        if ({csr_valid, req_ready} !== 2'b10 || csr_wdata !== 64'h77) begin
            n_mismatched++;
            $display("[TB] FAIL back_to_back: flags %b wdata %h expected 10 77", {csr_valid, req_ready}, csr_wdata);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        wb_ready = 1'b0;
        send(OpCSRRW, 1'b0, 5'd1, 64'h9, 5'd5, 12'h340, 64'h8000_0070, 1'b0, CauseInstrMisaligned, 64'h0);
        repeat (2) @(negedge clk);
        n_compared++;
        if (wb_valid !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_pre: wb_valid %b expected 1", wb_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        n_compared++;
        if ({wb_valid, req_ready} !== 2'b01 || wb_data !== 64'h0) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_async: flags %b data %h expected 01 0", {wb_valid, req_ready}, wb_data);
        end
        @(negedge clk);
        rst      = 1'b0;
        wb_ready = 1'b1;
        @(negedge clk);
        n_compared++;
        if ({req_ready, csr_valid, wb_valid, redirect_valid, csr_inst_ret} !== 5'b10000 ||
            {csr_wdata, wb_data, redirect_pc, wb_rd_idx} !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_after: flags %b wdata %h wb %h expected 10000 0 0",
                     {req_ready, csr_valid, wb_valid, redirect_valid, csr_inst_ret}, csr_wdata, wb_data);
        end
    endtask

    initial begin
        n_compared = 0;
        n_mismatched = 0;
        rst = 1'b1;
        req_valid = 1'b0; req_op = OpNone; req_imm = 1'b0; req_rs1_idx = '0; req_rs1_data = '0;
        req_rd_idx = '0; req_csr_addr = '0; req_pc = '0;
        req_expt_valid = 1'b0; req_expt_cause = CauseInstrMisaligned; req_expt_value = '0;
        wb_ready = 1'b1;
        test_reset();
        test_csrrw();
        test_read_only();
        test_ecall();
        test_mret();
        test_wb_stall();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
